// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-cache memory responder.
//   dmem_state_e : responder FSM states
//   LINE_WORDS   : words per line for the default geometry
//   SIZE_*       : dcache_mem_size encodings (informational; wstrb decides)
package dmem_pkg;

  localparam int unsigned WORD_W               = 32;
  localparam int unsigned DEFAULT_OFFSET_WIDTH = 2;
  localparam int unsigned LINE_WORDS           = 1 << DEFAULT_OFFSET_WIDTH;
  localparam int unsigned DELAY_W              = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DRAIN,
    ST_DELAY,
    ST_RESP_RD,
    ST_WR,
    ST_RESP_WR
  } dmem_state_e;

  // Words per line for a given offset width.
  function automatic int unsigned line_words(input int unsigned offset_width);
    return 1 << offset_width;
  endfunction

endpackage

// File: rtl/dmem_line_buf.sv
// Line assembly buffer: WORDS x 32-bit registers with one word-indexed write
// port and synchronous active-low clear.
//   clk, rstn       : clock, synchronous active-low clear
//   wr_en/idx/data  : write one word per cycle
//   line_q          : current contents, word k at [32k+31:32k]
//   line_nxt_c      : contents including this cycle's write (combinational)
module dmem_line_buf
  import dmem_pkg::*;
#(
  parameter int unsigned WORDS = LINE_WORDS,
  parameter int unsigned IDX_W = DEFAULT_OFFSET_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [WORD_W-1:0]         wr_data,
  output logic [WORDS*WORD_W-1:0]   line_q,
  output logic [WORDS*WORD_W-1:0]   line_nxt_c
);

  logic [WORDS-1:0][WORD_W-1:0] mem_q;
  logic [WORDS-1:0][WORD_W-1:0] mem_d;

  // Next contents: a single word replaced when writing.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign line_q     = mem_q;
  assign line_nxt_c = mem_d;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the L1 data cache memory port. Reads fetch a full
// line word by word from a synchronous RAM; writes are single byte-masked
// word stores. One request in flight at a time.
//   cache side : addr/dout/req/wr/size/wstrb in; addrOK (comb), dataOK, bvalid,
//                din_mem_dcache (line) out
//   RAM side   : ram_en/we/addr/wdata out (registered), ram_rdata in (1-cycle)
// Requires offset_width >= 1 and resp_delay in 0..15.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned offset_width = 2,
  parameter int unsigned resp_delay   = 0
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [31:0]                       addr_dcache_mem,
  input  logic [31:0]                       dout_dcache_mem,
  input  logic                              dcache_mem_req,
  input  logic                              dcache_mem_wr,
  input  logic [1:0]                        dcache_mem_size,
  input  logic [3:0]                        dcache_mem_wstrb,
  output logic                              mem_dcache_addrOK,
  output logic                              mem_dcache_dataOK,
  output logic                              mem_dcache_bvalid,
  output logic [32*(1<<offset_width)-1:0]   din_mem_dcache,
  output logic                              ram_en,
  output logic [3:0]                        ram_we,
  output logic [31:0]                       ram_addr,
  output logic [31:0]                       ram_wdata,
  input  logic [31:0]                       ram_rdata
);

  localparam int unsigned NWORDS = 1 << offset_width;
  localparam int unsigned LINE_W = WORD_W * NWORDS;
  localparam int unsigned TAG_W  = 32 - offset_width - 2;
  localparam logic [offset_width-1:0] CNT_LAST = '1;
  localparam logic [DELAY_W-1:0] DLY_LAST =
    DELAY_W'((resp_delay == 0) ? 0 : resp_delay - 1);
  localparam bit NO_DELAY = (resp_delay == 0);

  dmem_state_e               state_q, state_d;
  logic [offset_width-1:0]   cnt_q, cnt_d;
  logic                      cap_en_q, cap_en_d;
  logic [offset_width-1:0]   cap_idx_q, cap_idx_d;
  logic [DELAY_W-1:0]        dly_q, dly_d;
  logic [TAG_W-1:0]          line_addr_q, line_addr_d;
  logic                      wr_q, wr_d;
  logic                      dataok_q, dataok_d;
  logic                      bvalid_q, bvalid_d;
  logic                      ram_en_q, ram_en_d;
  logic [3:0]                ram_we_q, ram_we_d;
  logic [31:0]               ram_addr_q, ram_addr_d;
  logic [31:0]               ram_wdata_q, ram_wdata_d;
  logic [LINE_W-1:0]         din_q, din_d;
  logic [LINE_W-1:0]         line_buf_q;
  logic [LINE_W-1:0]         line_nxt_c;
  logic                      unused_sig_c;

  // Size is informational and the byte offset is implied by wstrb.
  assign unused_sig_c = ^{dcache_mem_size, addr_dcache_mem[1:0]};

  // Words return one cycle after issue; capture index trails the issue counter.
  dmem_line_buf #(
    .WORDS (NWORDS),
    .IDX_W (offset_width)
  ) u_line_buf (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (cap_en_q),
    .wr_idx     (cap_idx_q),
    .wr_data    (ram_rdata),
    .line_q     (line_buf_q),
    .line_nxt_c (line_nxt_c)
  );

  // Next-state and next-output logic. RAM outputs are registered, so the
  // access for the following cycle is decided here.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_en_d    = 1'b0;
    cap_idx_d   = cnt_q;
    dly_d       = dly_q;
    line_addr_d = line_addr_q;
    wr_d        = wr_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    din_d       = din_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dcache_mem_req) begin
          line_addr_d = addr_dcache_mem[31:offset_width+2];
          wr_d        = dcache_mem_wr;
          cnt_d       = '0;
          dly_d       = '0;
          if (!dcache_mem_wr) begin
            state_d    = ST_RD_ISSUE;
            ram_en_d   = 1'b1;
            ram_addr_d = {addr_dcache_mem[31:offset_width+2],
                          {offset_width{1'b0}}, 2'b00};
          end else if (dcache_mem_wstrb != 4'b0000) begin
            state_d     = ST_WR;
            ram_en_d    = 1'b1;
            ram_we_d    = dcache_mem_wstrb;
            ram_addr_d  = {addr_dcache_mem[31:2], 2'b00};
            ram_wdata_d = dout_dcache_mem;
          end else begin
            // Empty write: nothing to store, respond directly.
            state_d = NO_DELAY ? ST_RESP_WR : ST_DELAY;
          end
        end
      end

      ST_RD_ISSUE: begin
        cap_en_d  = 1'b1;
        cap_idx_d = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RD_DRAIN;
        end else begin
          ram_en_d   = 1'b1;
          ram_addr_d = {line_addr_q, cnt_d, 2'b00};
        end
      end

      ST_RD_DRAIN: begin
        state_d = NO_DELAY ? ST_RESP_RD : ST_DELAY;
      end

      ST_DELAY: begin
        if (dly_q == DLY_LAST) begin
          state_d = wr_q ? ST_RESP_WR : ST_RESP_RD;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      ST_WR: begin
        state_d = NO_DELAY ? ST_RESP_WR : ST_DELAY;
      end

      ST_RESP_RD,
      ST_RESP_WR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Publish the line on entry to RESP_RD; from RD_DRAIN the last word is
    // still being written, so take the buffer's next contents.
    if (state_d == ST_RESP_RD) begin
      din_d = (state_q == ST_RD_DRAIN) ? line_nxt_c : line_buf_q;
    end

    dataok_d = (state_d == ST_RESP_RD);
    bvalid_d = (state_d == ST_RESP_WR);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cap_en_q    <= 1'b0;
      cap_idx_q   <= '0;
      dly_q       <= '0;
      line_addr_q <= '0;
      wr_q        <= 1'b0;
      dataok_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_en_q    <= cap_en_d;
      cap_idx_q   <= cap_idx_d;
      dly_q       <= dly_d;
      line_addr_q <= line_addr_d;
      wr_q        <= wr_d;
      dataok_q    <= dataok_d;
      bvalid_q    <= bvalid_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      din_q       <= din_d;
    end
  end

  assign mem_dcache_addrOK = rstn & dcache_mem_req & (state_q == ST_IDLE);
  assign mem_dcache_dataOK = dataok_q;
  assign mem_dcache_bvalid = bvalid_q;
  assign din_mem_dcache    = din_q;
  assign ram_en            = ram_en_q;
  assign ram_we            = ram_we_q;
  assign ram_addr          = ram_addr_q;
  assign ram_wdata         = ram_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with resp_delay 0 and one with 3,
// each behind its own word RAM. Expected latencies, RAM access patterns and
// line contents come from a transaction-level memory model.
module tb_dmem_responder;

  localparam int unsigned OW        = 2;
  localparam int unsigned N         = 1 << OW;
  localparam int unsigned LW        = 32 * N;
  localparam int unsigned RAM_WORDS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rstn;
  logic [31:0]   addr, dout;
  logic          req0, req3, req_wr;
  logic [1:0]    size;
  logic [3:0]    wstrb;

  logic          aok0, dok0, bv0, en0;
  logic          aok3, dok3, bv3, en3;
  logic [3:0]    we0, we3;
  logic [31:0]   ra0, ra3, wd0, wd3, rd0, rd3;
  logic [LW-1:0] din0, din3;

  dmem_responder #(.offset_width(OW), .resp_delay(0)) dut0 (
    .clk(clk), .rstn(rstn), .addr_dcache_mem(addr), .dout_dcache_mem(dout),
    .dcache_mem_req(req0), .dcache_mem_wr(req_wr), .dcache_mem_size(size),
    .dcache_mem_wstrb(wstrb), .mem_dcache_addrOK(aok0), .mem_dcache_dataOK(dok0),
    .mem_dcache_bvalid(bv0), .din_mem_dcache(din0), .ram_en(en0), .ram_we(we0),
    .ram_addr(ra0), .ram_wdata(wd0), .ram_rdata(rd0));

  dmem_responder #(.offset_width(OW), .resp_delay(3)) dut3 (
    .clk(clk), .rstn(rstn), .addr_dcache_mem(addr), .dout_dcache_mem(dout),
    .dcache_mem_req(req3), .dcache_mem_wr(req_wr), .dcache_mem_size(size),
    .dcache_mem_wstrb(wstrb), .mem_dcache_addrOK(aok3), .mem_dcache_dataOK(dok3),
    .mem_dcache_bvalid(bv3), .din_mem_dcache(din3), .ram_en(en3), .ram_we(we3),
    .ram_addr(ra3), .ram_wdata(wd3), .ram_rdata(rd3));

  // Word RAMs with a preload port used during reset.
  logic          pl_en;
  logic [7:0]    pl_idx;
  logic [31:0]   pl_data;
  logic [31:0]   ram0 [RAM_WORDS];
  logic [31:0]   ram3 [RAM_WORDS];

  always @(posedge clk) begin
    if (pl_en) ram0[pl_idx] <= pl_data;
    else if (en0) begin
      for (int b = 0; b < 4; b++)
        if (we0[b]) ram0[ra0[9:2]][8*b +: 8] <= wd0[8*b +: 8];
      rd0 <= ram0[ra0[9:2]];
    end
  end

  always @(posedge clk) begin
    if (pl_en) ram3[pl_idx] <= pl_data;
    else if (en3) begin
      for (int b = 0; b < 4; b++)
        if (we3[b]) ram3[ra3[9:2]][8*b +: 8] <= wd3[8*b +: 8];
      rd3 <= ram3[ra3[9:2]];
    end
  end

  // Selected-instance view.
  bit            sel;
  logic          s_aok, s_dok, s_bv, s_en;
  logic [3:0]    s_we;
  logic [31:0]   s_addr, s_wdata;
  logic [LW-1:0] s_din;
  always_comb begin
    s_aok   = sel ? aok3 : aok0;
    s_dok   = sel ? dok3 : dok0;
    s_bv    = sel ? bv3  : bv0;
    s_en    = sel ? en3  : en0;
    s_we    = sel ? we3  : we0;
    s_addr  = sel ? ra3  : ra0;
    s_wdata = sel ? wd3  : wd0;
    s_din   = sel ? din3 : din0;
  end

  // Reference model: memory image per instance and last line delivered.
  logic [31:0]   ref_mem [2][RAM_WORDS];
  logic [LW-1:0] ref_din [2];

  int checks   = 0;
  int failures = 0;

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_v(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request and wait (bounded) for acceptance; the responder is
  // idle whenever this is called, so acceptance must be immediate.
  task automatic issue(input bit wr_i, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int t_acc);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    addr = a; dout = d; req_wr = wr_i; wstrb = s; size = 2'd2;
    req0 = !sel; req3 = sel;
    @(negedge clk);
    while (!s_aok && waited < 30) begin
      waited++;
      @(negedge clk);
    end
    check_i("accept_wait", waited, 0);
    t_acc = cyc;
  endtask

  // Follow an accepted request to its response and compare against the model.
  task automatic complete(input bit wr_i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int t_acc, input int exp_lat,
                          input bit hold, output logic [LW-1:0] line_o);
    int t_resp, nops, idx, base_idx;
    bit bad_busy, bad_op, bad_pulse;
    logic [31:0] base;
    logic [LW-1:0] exp_line, resp_din;
    t_resp = -1; nops = 0; bad_busy = 0; bad_op = 0; bad_pulse = 0;
    resp_din = '0;
    base = a & ~32'(4 * N - 1);
    if (!hold) begin
      @(posedge clk); #1;
      req0 = 1'b0; req3 = 1'b0;
    end
    for (int k = 0; k < 40 && t_resp < 0; k++) begin
      @(negedge clk);
      if (hold && s_aok) bad_busy = 1;
      if (s_en) begin
        if (wr_i) begin
          if (cyc != t_acc + 1 || s == 4'b0000 || s_we != s ||
              s_addr != {a[31:2], 2'b00} || s_wdata != d) bad_op = 1;
        end else begin
          if (cyc != t_acc + 1 + nops || s_we != 4'b0000 ||
              s_addr != base + 32'(4 * nops)) bad_op = 1;
        end
        nops++;
      end
      if (s_dok || s_bv) begin
        t_resp = cyc;
        resp_din = s_din;
        if (wr_i ? (s_dok || !s_bv) : (s_bv || !s_dok)) bad_pulse = 1;
      end
    end
    check_i("latency", t_resp - t_acc, exp_lat);
    check_i("ram_ops", nops, wr_i ? ((s != 4'b0000) ? 1 : 0) : N);
    check_i("ram_op_shape", int'(bad_op), 0);
    check_i("resp_kind", int'(bad_pulse), 0);
    if (hold) check_i("busy_addrok", int'(bad_busy), 0);
    idx = int'(a[9:2]);
    if (wr_i) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[sel][idx][8*b +: 8] = d[8*b +: 8];
      check_v("din_kept", resp_din, ref_din[sel]);
    end else begin
      base_idx = int'(base[9:2]);
      for (int k = 0; k < N; k++) exp_line[32*k +: 32] = ref_mem[sel][base_idx + k];
      ref_din[sel] = exp_line;
      check_v("read_line", resp_din, exp_line);
    end
    line_o = resp_din;
  endtask

  task automatic txn(input bit sel_i, input bit wr_i, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input int exp_lat,
                     input bit hold, output int t_acc, output logic [LW-1:0] line_o);
    sel = sel_i;
    issue(wr_i, a, d, s, t_acc);
    complete(wr_i, a, d, s, t_acc, exp_lat, hold, line_o);
  endtask

  typedef struct {
    bit          sel3;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int t, t2;
    logic [LW-1:0] line, line_rd, plan_line;
    logic [31:0] w, a;
    bit wr_r, s3;
    logic [3:0] st;

    rstn = 1'b0; req0 = 1'b1; req3 = 1'b0; req_wr = 1'b0; addr = '0; dout = '0;
    size = 2'd2; wstrb = '0; pl_en = 1'b0; pl_idx = '0; pl_data = '0; sel = 1'b0;
    ref_din[0] = '0; ref_din[1] = '0;

    // Preload both RAMs and the model while reset is held (req high).
    for (int i = 0; i < RAM_WORDS; i++) begin
      w = $urandom;
      if (i >= 64 && i < 68) w = 32'hA0 + 32'(i - 64);
      if (i == 129) w = 32'hDEADBEEF;
      @(posedge clk); #1;
      pl_en = 1'b1; pl_idx = 8'(i); pl_data = w;
      ref_mem[0][i] = w; ref_mem[1][i] = w;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
    check_i("addrok_in_reset", int'(aok0), 0);
    @(posedge clk); #1;
    req0 = 1'b0; rstn = 1'b1;
    @(negedge clk);
    check_i("rst_addrok", int'(aok0), 0);
    check_i("rst_dataok", int'(dok0), 0);
    check_i("rst_bvalid", int'(bv0), 0);
    check_i("rst_ram_en", int'(en0), 0);
    check_i("rst_ram_we", int'(we0), 0);
    check_v("rst_ram_addr", LW'(ra0), '0);
    check_v("rst_ram_wdata", LW'(wd0), '0);
    check_v("rst_din", din0, '0);

    // Line read of 0x100.
    plan_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 6, 1'b0, t, line);
    check_v("plan_read_line", line, plan_line);

    // Byte write into word 0x204, then read its line back.
    txn(1'b0, 1'b1, 32'h204, 32'h11223344, 4'b0100, 2, 1'b0, t, line);
    txn(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 6, 1'b0, t, line);
    check_v("plan_merged_word", LW'(line[63:32]), LW'(32'hDE22BEEF));

    // Request held through a busy read; the next one lands right after.
    txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 6, 1'b1, t, line_rd);
    txn(1'b0, 1'b1, 32'h208, 32'hCAFEF00D, 4'b1111, 2, 1'b0, t2, line);
    check_i("busy_next_accept", t2 - t, 7);
    check_v("din_after_write", line, line_rd);
    check_v("din_after_write_now", din0, line_rd);

    // Table of vectors over both instances.
    vecs[0] = '{1'b0, 1'b1, 32'h0F8, 32'h55555555, 4'b0000, 1};
    vecs[1] = '{1'b0, 1'b1, 32'h3FE, 32'h89ABCDEF, 4'b1111, 2};
    vecs[2] = '{1'b0, 1'b0, 32'h3F0, 32'h0,        4'b0000, 6};
    vecs[3] = '{1'b0, 1'b1, 32'h100, 32'h77665544, 4'b0011, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'b0000, 6};
    vecs[5] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'b0000, 9};
    vecs[6] = '{1'b1, 1'b1, 32'h104, 32'h12345678, 4'b0000, 4};
    vecs[7] = '{1'b1, 1'b1, 32'h10C, 32'hF1E2D3C4, 4'b1001, 5};
    vecs[8] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'b0000, 9};
    vecs[9] = '{1'b1, 1'b0, 32'h000, 32'h0,        4'b0000, 9};
    for (int i = 0; i < 10; i++)
      txn(vecs[i].sel3, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
          vecs[i].lat, 1'b0, t, line);

    // Reset in the middle of a read on the delay-0 instance.
    sel = 1'b0;
    issue(1'b0, 32'h040, 32'h0, 4'h0, t);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check_i("midrst_no_dataok_t3", int'(dok0), 0);
    @(negedge clk);
    check_i("midrst_dataok", int'(dok0), 0);
    check_i("midrst_ram_en", int'(en0), 0);
    check_i("midrst_ram_we", int'(we0), 0);
    check_v("midrst_ram_addr", LW'(ra0), '0);
    check_v("midrst_ram_wdata", LW'(wd0), '0);
    check_v("midrst_din", din0, '0);
    check_i("midrst_bvalid", int'(bv0), 0);
    rstn = 1'b1;
    ref_din[0] = '0; ref_din[1] = '0;
    txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 6, 1'b0, t, line);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      s3   = ($urandom_range(0, 3) == 0);
      wr_r = 1'($urandom_range(0, 1));
      a    = 32'($urandom_range(0, RAM_WORDS * 4 - 1));
      if (!wr_r) a = a & ~32'(4 * N - 1);
      st   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      w    = $urandom;
      txn(s3, wr_r, a, w, st,
          wr_r ? ((st != 4'b0000 ? 2 : 1) + (s3 ? 3 : 0)) : (N + 2 + (s3 ? 3 : 0)),
          1'($urandom_range(0, 1)), t, line);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req3 = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the L1 data cache's memory port. It accepts one read or write request at a time from the cache, serves reads by fetching a full cache line from a word-wide synchronous RAM, and serves writes as single byte-masked word stores. It sits between the data cache and the on-chip data RAM, or a RAM-like bridge, and also serves as the reference responder in cache testbenches.

## Interface
- offset_width, 2: log2 of words per line; the line is 32*(1<<offset_width) bits.
- resp_delay, 0: extra idle cycles inserted before each dataOK/bvalid pulse (0..15).
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low.
- addr_dcache_mem  in  32  request address; line-aligned for reads, word address for writes.
- dout_dcache_mem  in  32  write data.
- dcache_mem_req  in  1  request valid; held by the cache until addrOK.
- dcache_mem_wr  in  1  0 = read, 1 = write.
- dcache_mem_size  in  2  0/1/2 = 1/2/4 bytes; informational only, wstrb is authoritative.
- dcache_mem_wstrb  in  4  write byte enables.
- mem_dcache_addrOK  out  1  request accepted this cycle.
- mem_dcache_dataOK  out  1  one-cycle pulse: read line valid.
- mem_dcache_bvalid  out  1  one-cycle pulse: write completed.
- din_mem_dcache  out  32*(1<<offset_width)  read line; word k at bits [32k+31:32k].
- ram_en  out  1  RAM access enable.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  32  RAM byte address, always word-aligned.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid the cycle after ram_en with ram_we == 0.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_DRAIN, DELAY, RESP_RD, WR, RESP_WR.
- IDLE: mem_dcache_addrOK = dcache_mem_req, combinational and gated by rstn. On acceptance, latch addr, wr, wstrb, and data.
  - wr = 0 → RD_ISSUE.
  - wr = 1 with wstrb ≠ 0 → WR.
  - wr = 1 with wstrb = 0 → DELAY/RESP_WR. No RAM access occurs.
- RD_ISSUE:
  - Word counter cnt runs 0..N-1, where N = 1<<offset_width.
  - Drive ram_en = 1, ram_we = 0, ram_addr = {addr[31:offset_width+2], cnt, 2'b00}.
  - The counter wraps inside the line and never carries into the line address.
  - After cnt = N-1 → RD_DRAIN.
- Line buffer capture: ram_rdata is written into word (cnt delayed by one cycle), in both RD_ISSUE and RD_DRAIN.
- RD_DRAIN: capture the last word, then go to DELAY, or to RESP_RD if resp_delay = 0.
- DELAY: count resp_delay cycles, then go to RESP_RD or RESP_WR according to the latched wr.
- RESP_RD: dataOK = 1 for one cycle → IDLE.
  - din_mem_dcache shows the assembled line while in RESP_RD.
  - It holds that value until the next read's RESP_RD.
  - Writes do not change it.
- WR: ram_en = 1, ram_we = latched wstrb, ram_addr = {addr[31:2], 2'b00}, ram_wdata = latched data. Takes one cycle, then → DELAY/RESP_WR.
- RESP_WR: bvalid = 1 for one cycle → IDLE.
- Request handling:
  - dataOK and bvalid are never asserted together.
  - A req arriving outside IDLE is ignored (addrOK = 0); the cache keeps holding it.
  - A new request is accepted at the earliest in the cycle after RESP_*.
- Reset: rstn low at a clock edge returns the FSM to IDLE from any state. The in-flight request is dropped with no response pulse, and the line buffer clears to 0.

## Timing
- Reset values: addrOK 0, dataOK 0, bvalid 0, din_mem_dcache 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0.
- Read accepted in cycle T:
  - RAM issues occur in T+1..T+N.
  - Last word is captured at the end of T+N+1.
  - dataOK is asserted in T+N+2+resp_delay (T+6 for N = 4 and delay 0).
- Write accepted in cycle T: RAM write in T+1; bvalid in T+2+resp_delay.
- Write with wstrb = 0 accepted in T: bvalid in T+1+resp_delay.
- Back-to-back throughput: one read per N+3+resp_delay cycles; one write per 3+resp_delay cycles.

## Structure
- Shared package dmem_pkg holds:
  - the state enum;
  - LINE_WORDS = 1<<offset_width;
  - localparams for size encodings 0/1/2.
- One sub-module, dmem_line_buf: N×32 register array with a word-indexed write port, a clear on reset, and a flat line output.

## Test plan
- Read: RAM words at 0x100..0x10C = 0xA0,0xA1,0xA2,0xA3; req read at addr 0x100 in cycle T.
  - Required: addrOK in T; ram_addr 0x100,0x104,0x108,0x10C in T+1..T+4.
  - Required: dataOK in T+6; line = {0xA3,0xA2,0xA1,0xA0}.
- Write: addr 0x204, data 0x11223344, wstrb 4'b0100.
  - Required: ram_we = 0100 at ram_addr 0x204 in T+1; bvalid in T+2.
  - Required: a subsequent read of line 0x200 returns word1 = old word with byte2 replaced by 0x22.
- Busy and idle-after-response: hold req high during a read.
  - Required: addrOK stays 0 until IDLE; the next request is accepted in T+7.
  - Required: din_mem_dcache is unchanged after an intervening write.
- resp_delay = 3 and wstrb = 0:
  - Read dataOK in T+9.
  - Write with wstrb 0 gives bvalid in T+4 with no ram_en.
- Reset mid-read: rstn low in T+3.
  - Required: all outputs 0 the next cycle and no dataOK.
  - Required: a new request is accepted in the first cycle after rstn returns high.
